// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM pipeline stage and a word-wide data memory.
// Rebases the CPU address onto the data segment, builds byte enables and
// lane-replicated store data, extends load results and bounds the wait for
// m_ack_i with a timeout counter.
module mem_access_unit #(
  parameter logic [31:0] DATA_BASE   = 32'h0000_2000,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  size_i,
  input  logic        signed_ld_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_wdata_o,
  output logic [3:0]  m_be_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_rdata_i
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [31:0] adr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [1:0]  size_q, off_q;
  logic        signed_q;
  logic [CntW-1:0] cnt_q;
  logic        timeout_q;

  logic        req, aligned, start, cnt_last;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, lane_sh, load_ext;

  assign req      = mem_read_i | mem_write_i;
  assign start    = (state_q == StIdle) && req && aligned;
  assign cnt_last = (cnt_q == CntLast);
  assign lane_sh  = m_rdata_i >> {off_q, 3'b000};

  // Alignment check, byte enables and store-lane replication from the live request
  always_comb begin
    aligned   = 1'b1;
    be_new    = 4'b1111;
    wdata_new = wdata_i;
    unique case (size_i)
      2'b00: begin
        be_new    = 4'b0001 << adr_i[1:0];
        wdata_new = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        aligned   = ~adr_i[0];
        be_new    = 4'b0011 << adr_i[1:0];
        wdata_new = {2{wdata_i[15:0]}};
      end
      default: aligned = (adr_i[1:0] == 2'b00);
    endcase
  end

  // Pick the addressed lane of the returned word and extend it
  always_comb begin
    load_ext = lane_sh;
    unique case (size_q)
      2'b00: load_ext = {{24{signed_q & lane_sh[7]}}, lane_sh[7:0]};
      2'b01: load_ext = {{16{signed_q & lane_sh[15]}}, lane_sh[15:0]};
      default: load_ext = lane_sh;
    endcase
  end

  // Next-state logic; ack beats a coincident timeout because both end in DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req && aligned) state_d = StBusy;
      StBusy: if (m_ack_i || cnt_last) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Request latch, wait counter, load result and timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q      <= 1'b0;
      adr_q     <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      size_q    <= '0;
      off_q     <= '0;
      signed_q  <= 1'b0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (start) begin
        we_q     <= mem_write_i;
        adr_q    <= (adr_i - DATA_BASE) & 32'hFFFF_FFFC;
        wdata_q  <= wdata_new;
        be_q     <= be_new;
        size_q   <= size_i;
        off_q    <= adr_i[1:0];
        signed_q <= signed_ld_i;
        cnt_q    <= '0;
      end else if (state_q == StBusy) begin
        if (m_ack_i) begin
          rdata_q <= we_q ? 32'h0 : load_ext;
        end else if (cnt_last) begin
          rdata_q   <= 32'h0;
          timeout_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign m_req_o    = (state_q == StBusy);
  assign m_we_o     = we_q;
  assign m_adr_o    = adr_q;
  assign m_wdata_o  = wdata_q;
  assign m_be_o     = be_q;
  assign rdata_o    = rdata_q;
  assign timeout_o  = timeout_q;
  assign misalign_o = (state_q == StIdle) && req && !aligned;
  assign stall_o    = (state_q == StBusy) || start;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset and
// misalignment sequences, then randomized transactions against an arithmetic model.
module tb_mem_access_unit;

  localparam logic [31:0] Base = 32'h0000_2000;
  localparam int Tmo = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read_i = 1'b0, mem_write_i = 1'b0, signed_ld_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic [31:0] adr_i = '0, wdata_i = '0, m_rdata_i = '0;
  logic        m_ack_i = 1'b0;
  logic [31:0] rdata_o, m_adr_o, m_wdata_o;
  logic        stall_o, misalign_o, timeout_o, m_req_o, m_we_o;
  logic [3:0]  m_be_o;

  mem_access_unit #(.DATA_BASE(Base), .TIMEOUT_CYC(Tmo)) dut (
    .clk(clk), .rst(rst), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .size_i(size_i), .signed_ld_i(signed_ld_i), .adr_i(adr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .stall_o(stall_o), .misalign_o(misalign_o), .timeout_o(timeout_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o), .m_wdata_o(m_wdata_o),
    .m_be_o(m_be_o), .m_ack_i(m_ack_i), .m_rdata_i(m_rdata_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_aligned(input logic [1:0] sz, input logic [31:0] adr);
    return (longint'(adr) % nbytes(sz)) == 0;
  endfunction

  function automatic logic [31:0] model_adr(input logic [31:0] adr);
    longint m;
    m = (longint'(adr) + 64'h1_0000_0000 - longint'(Base)) % 64'h1_0000_0000;
    return 32'((m / 4) * 4);
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] adr);
    int n, off;
    n = nbytes(sz);
    off = int'(longint'(adr) % 4);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
    longint w;
    w = longint'(wd);
    if (nbytes(sz) == 1) return 32'((w % 256) * 64'h0101_0101);
    if (nbytes(sz) == 2) return 32'((w % 65536) * 64'h0001_0001);
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg,
                                             input logic [31:0] adr, input logic [31:0] mr);
    longint lane, span;
    int n, off;
    n = nbytes(sz);
    off = int'(longint'(adr) % 4);
    span = longint'(1) << (8 * n);
    lane = (longint'(mr) >> (8 * off)) % span;
    if (sg && lane >= span / 2) lane = lane - span;
    return 32'(lane);
  endfunction

  // ---------------- transaction driver/checker ----------------
  task automatic do_txn(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] adr, input logic [31:0] wd, input logic [31:0] mr,
                        input int dly, input logic [31:0] e_adr, input logic [3:0] e_be,
                        input logic [31:0] e_wd, input logic [31:0] e_rd, input logic e_to);
    int nb;
    mem_read_i = rd; mem_write_i = wr; size_i = sz; signed_ld_i = sg;
    adr_i = adr; wdata_i = wd; m_ack_i = 1'b0;
    #1;
    check("stall_req_idle", 32'(stall_o), 32'd1);
    check("misalign_aligned", 32'(misalign_o), 32'd0);
    check("req_before_busy", 32'(m_req_o), 32'd0);
    step();
    nb = (dly < Tmo) ? dly + 1 : Tmo;
    for (int i = 0; i < nb; i++) begin
      check("req_busy", 32'(m_req_o), 32'd1);
      check("stall_busy", 32'(stall_o), 32'd1);
      if (i == 0) begin
        check("m_adr", m_adr_o, e_adr);
        check("m_be", 32'(m_be_o), 32'(e_be));
        check("m_we", 32'(m_we_o), 32'(wr));
        check("m_wdata", m_wdata_o, e_wd);
      end
      m_ack_i   = (i == dly);
      m_rdata_i = (i == dly) ? mr : $urandom();
      step();
    end
    m_ack_i = 1'b0;
    // DONE
    check("req_done", 32'(m_req_o), 32'd0);
    check("stall_done", 32'(stall_o), 32'd0);
    check("timeout_done", 32'(timeout_o), 32'(e_to));
    check("rdata_done", rdata_o, e_rd);
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    m_ack_i = 1'b1; m_rdata_i = $urandom();  // must be ignored in DONE
    step();
    m_ack_i = 1'b0;
    // back in IDLE
    check("req_after", 32'(m_req_o), 32'd0);
    check("stall_after", 32'(stall_o), 32'd0);
    check("timeout_after", 32'(timeout_o), 32'd0);
    check("rdata_hold", rdata_o, e_rd);
  endtask

  task automatic do_misalign(input logic [1:0] sz, input logic [31:0] adr,
                             input logic [31:0] e_rd);
    mem_read_i = 1'b1; size_i = sz; adr_i = adr;
    #1;
    check("misalign_flag", 32'(misalign_o), 32'd1);
    check("misalign_stall", 32'(stall_o), 32'd0);
    step();
    check("misalign_noreq", 32'(m_req_o), 32'd0);
    check("misalign_rdata", rdata_o, e_rd);
    mem_read_i = 1'b0;
    #1;
    check("misalign_clear", 32'(misalign_o), 32'd0);
  endtask

  typedef struct {
    logic        rd, wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] adr, wd, mr;
    int          dly;
    logic [31:0] e_adr;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd;
    logic        e_to;
  } vec_t;

  vec_t vecs[9];
  logic [31:0] last_rd;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h2008, 32'h1122_3344, 32'hDEAD_BEEF, 2,
                32'h8, 4'hF, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h2003, 32'h0000_00AB, 32'h8012_3456, 0,
                32'h0, 4'h8, 32'hABAB_ABAB, 32'hFFFF_FF80, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h2003, 32'h0000_00AB, 32'h8012_3456, 0,
                32'h0, 4'h8, 32'hABAB_ABAB, 32'h0000_0080, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h2006, 32'h0000_ABCD, 32'h0, 1,
                32'h4, 4'hC, 32'hABCD_ABCD, 32'h0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 32'h8001_7FFF, 3,
                32'h0, 4'hC, 32'h0, 32'hFFFF_8001, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h2010, 32'h0, 32'h0, 100,
                32'h10, 4'hF, 32'h0, 32'h0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 2'b00, 1'b0, 32'h2001, 32'h0000_005A, 32'hFFFF_FFFF, 0,
                32'h0, 4'h2, 32'h5A5A_5A5A, 32'h0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h1234_5678, 15,
                32'hFFFF_E004, 4'hF, 32'h0, 32'h1234_5678, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 2'b10, 1'b1, 32'h2000, 32'h0, 32'h0, 16,
                32'h0, 4'hF, 32'h0, 32'h0, 1'b1};

    // Reset state
    #1;
    check("rst_req", 32'(m_req_o), 32'd0);
    check("rst_adr", m_adr_o, 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    step();
    step();
    rst = 1'b0;

    // Ack while idle with no request must be ignored
    m_ack_i = 1'b1; m_rdata_i = 32'hFFFF_FFFF;
    step();
    check("idle_ack_noreq", 32'(m_req_o), 32'd0);
    check("idle_ack_rdata", rdata_o, 32'h0);
    m_ack_i = 1'b0;

    foreach (vecs[k])
      do_txn(vecs[k].rd, vecs[k].wr, vecs[k].sz, vecs[k].sg, vecs[k].adr, vecs[k].wd,
             vecs[k].mr, vecs[k].dly, vecs[k].e_adr, vecs[k].e_be, vecs[k].e_wd,
             vecs[k].e_rd, vecs[k].e_to);

    // Misaligned word and half
    do_misalign(2'b10, 32'h2002, 32'h0);
    do_misalign(2'b01, 32'h2005, 32'h0);

    // Load a non-zero value, then reset in the middle of BUSY
    do_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h2008, 32'h0, 32'hCAFE_F00D, 0,
           32'h8, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0);
    mem_read_i = 1'b1; size_i = 2'b10; adr_i = 32'h200C; wdata_i = 32'h0;
    step();
    check("pre_rst_busy", 32'(m_req_o), 32'd1);
    step();
    rst = 1'b1;
    #1;
    check("midrst_req", 32'(m_req_o), 32'd0);
    check("midrst_we", 32'(m_we_o), 32'd0);
    check("midrst_adr", m_adr_o, 32'h0);
    check("midrst_wdata", m_wdata_o, 32'h0);
    check("midrst_be", 32'(m_be_o), 32'd0);
    check("midrst_rdata", rdata_o, 32'h0);
    check("midrst_timeout", 32'(timeout_o), 32'd0);
    step();
    check("rst_held_req", 32'(m_req_o), 32'd0);
    rst = 1'b0;
    // Request still present after reset: served from the next edge
    do_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h200C, 32'h0, 32'h0BAD_CAFE, 1,
           32'hC, 4'hF, 32'h0, 32'h0BAD_CAFE, 1'b0);
    last_rd = 32'h0BAD_CAFE;

    // Randomized transactions against the model
    for (int t = 0; t < 60; t++) begin
      logic [1:0]  sz;
      logic        sg, rd, wr;
      logic [31:0] adr, wd, mr, e_rd;
      int          dly, kind;
      sz   = 2'($urandom_range(0, 3));
      sg   = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 2);
      rd   = (kind != 1);
      wr   = (kind != 0);
      adr  = ($urandom_range(0, 7) == 0) ? $urandom() : Base + $urandom_range(0, 255);
      wd   = $urandom();
      mr   = $urandom();
      dly  = $urandom_range(0, 18);
      if (model_aligned(sz, adr)) begin
        if (wr || dly >= Tmo) e_rd = 32'h0;
        else e_rd = model_load(sz, sg, adr, mr);
        do_txn(rd, wr, sz, sg, adr, wd, mr, dly, model_adr(adr), model_be(sz, adr),
               model_wdata(sz, wd), e_rd, (dly >= Tmo));
        last_rd = e_rd;
      end else begin
        do_misalign(sz, adr, last_rd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
